instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 16-bit CPU, directly upstream of CPU_Controller.
- Holds the program counter (PC) and fetches instruction words from synchronous memory with a req/valid handshake.
- Latches each fetched word into the instruction register (IR) and presents decoded fields (opcode, opcode_ext, rdest, rsrc, imm8) to the controller.
- Applies the controller's PC update commands: pc_en, pc_addr_mode.

Parameters:
- ADDR_WIDTH, 16, width of PC and memory address.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- next_instr  in  1  controller request to fetch the word at PC.
- instr_en  in  1  load the fetched word into IR.
- pc_en  in  1  update PC this cycle.
- pc_addr_mode  in  2  00 INCREMENT, 01 OFFSET, 10 ABSOLUTE, 11 hold.
- jump_target  in  ADDR_WIDTH  absolute target (Rtarget register value).
- mem_addr  out  ADDR_WIDTH  fetch address.
- mem_rd_req  out  1  one-cycle read request strobe.
- mem_rd_data  in  16  returned instruction word.
- mem_rd_valid  in  1  mem_rd_data valid this cycle.
- instr_ready  out  1  fetch buffer holds a word for the current PC.
- opcode  out  4  IR[15:12].
- rdest  out  4  IR[11:8] (condition code for Bcond/Jcond).
- opcode_ext  out  4  IR[7:4].
- rsrc  out  4  IR[3:0].
- imm8  out  8  IR[7:0].
- pc  out  ADDR_WIDTH  address of the instruction held in IR.
- pc_plus1  out  ADDR_WIDTH  pc+1, used as the JAL link value (combinational from pc).

Behaviour:
- Reset (async):
  - pc=RESET_PC, IR=16'h0000, fetch_addr=RESET_PC.
  - State IDLE, mem_rd_req=0, instr_ready=0, stale flag=0.
- Field outputs are registered through IR only; they change solely on an instr_en load.
- FSM states: IDLE, REQ, WAIT, READY.
  - IDLE: next_instr=1 -> fetch_addr<=pc, go to REQ. Otherwise stay.
  - REQ: mem_rd_req=1 for exactly one cycle, mem_addr=fetch_addr, then go to WAIT.
  - WAIT: hold mem_addr.
    - mem_rd_valid=1 and not stale -> buf<=mem_rd_data, go to READY.
    - mem_rd_valid=1 and stale -> clear stale, fetch_addr<=pc, go to REQ (refetch).
  - READY: instr_ready=1.
    - instr_en=1 -> IR<=buf, go to IDLE. instr_ready drops the next cycle.
- mem_rd_valid is honoured only in WAIT; in any other state it is ignored.
- Minimum fetch latency: next_instr at cycle N gives REQ at N+1 and WAIT from N+2; READY follows the cycle after mem_rd_valid is seen.
- next_instr outside IDLE is ignored. instr_en outside READY is ignored (IR unchanged).
- PC update on pc_en=1, modulo 2^ADDR_WIDTH with silent wrap:
  - INCREMENT: pc+1.
  - OFFSET: pc + sign_extend(imm8).
  - ABSOLUTE: jump_target.
  - 11: hold.
- pc_en during REQ or WAIT with a PC change: set stale. The in-flight response is discarded and the word is refetched.
- pc_en in READY with a PC change: discard buf, go to REQ with the new pc.
- pc_en and instr_en in the same cycle in READY: the IR load wins using the old buf; the PC update still applies.
- Mode 11 never sets stale.

Optional Feature:
- Macro FETCH_PREFETCH_EN.
- When defined:
  - An instr_en load immediately issues a speculative fetch of pc+1 (IDLE is skipped, go to REQ with fetch_addr=pc+1).
  - A later next_instr with pc==fetch_addr and a valid buf goes straight to READY.
  - If pc differs, the buffer is discarded and the word at pc is refetched.
  - Gains 2 cycles per sequential instruction.
- When undefined: fetch starts only on next_instr, as above.

Test Plan:
- Reset, then next_instr; memory returns 16'h0521 one cycle after req -> mem_addr=0, mem_rd_req high for one cycle; after instr_en: opcode=0, rdest=5, opcode_ext=2, rsrc=1, instr_ready=0.
- pc=16'h0010, pc_en with INCREMENT -> pc=16'h0011. IR imm8=8'hFE with OFFSET -> pc=16'h000F. ABSOLUTE with jump_target=16'h1234 -> pc=16'h1234.
- pc=16'hFFFF with INCREMENT -> pc=16'h0000; pc_plus1 at 16'hFFFF reads 16'h0000.
- In WAIT, pc_en ABSOLUTE to 16'h0040, then mem_rd_valid with 16'hAAAA -> data discarded; a second req issued with mem_addr=16'h0040; the IR finally holds that word.
- Reset asserted in WAIT with mem_rd_valid pending -> immediately pc=RESET_PC, instr_ready=0, mem_rd_req=0; the late valid is ignored.
- With FETCH_PREFETCH_EN: load at pc=4, pc_en INCREMENT, next_instr -> instr_ready high the next cycle with no new req. Same sequence with OFFSET -> refetch from the new pc.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - Controller and instruction-memory signals of the fetch unit
// slave: the fetch unit itself; master: the controller/memory side driving it.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  next_instr;
    logic                  instr_en;
    logic                  pc_en;
    logic [1:0]            pc_addr_mode;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_req;
    logic [15:0]           mem_rd_data;
    logic                  mem_rd_valid;
    logic                  instr_ready;
    logic [3:0]            opcode;
    logic [3:0]            rdest;
    logic [3:0]            opcode_ext;
    logic [3:0]            rsrc;
    logic [7:0]            imm8;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus1;

    modport slave (
        input  next_instr, instr_en, pc_en, pc_addr_mode, jump_target,
        input  mem_rd_data, mem_rd_valid,
        output mem_addr, mem_rd_req, instr_ready,
        output opcode, rdest, opcode_ext, rsrc, imm8, pc, pc_plus1
    );

    modport master (
        output next_instr, instr_en, pc_en, pc_addr_mode, jump_target,
        output mem_rd_data, mem_rd_valid,
        input  mem_addr, mem_rd_req, instr_ready,
        input  opcode, rdest, opcode_ext, rsrc, imm8, pc, pc_plus1
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, fetch FSM and instruction register of the 16-bit CPU front end
// Optional speculative next-word prefetch is enabled by defining FETCH_PREFETCH_EN.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.slave bus
);

`ifdef FETCH_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, REQ, WAIT, READY} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [15:0]           ir_q, ir_d;
    logic [15:0]           buf_q, buf_d;
    logic                  stale_q, stale_d;
    logic                  spec_q, spec_d;
    logic                  buf_valid_q, buf_valid_d;
    logic                  pc_change;
    logic                  mark_stale;
    logic [ADDR_WIDTH-1:0] imm_sext;

    assign imm_sext = {{(ADDR_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

    // PC arithmetic wraps silently at 2^ADDR_WIDTH; hold mode is never a change.
    always_comb begin
        pc_d      = pc_q;
        pc_change = 1'b0;
        if (bus.pc_en) begin
            pc_change = (bus.pc_addr_mode != 2'b11);
            case (bus.pc_addr_mode)
                2'b00:   pc_d = pc_q + ADDR_WIDTH'(1);
                2'b01:   pc_d = pc_q + imm_sext;
                2'b10:   pc_d = bus.jump_target;
                default: pc_d = pc_q;
            endcase
        end
    end

    // A speculative fetch is matched against the PC when it lands, so it never goes stale.
    assign mark_stale = pc_change && !spec_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        buf_d        = buf_q;
        stale_d      = stale_q;
        spec_d       = spec_q;
        buf_valid_d  = buf_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.next_instr) begin
                    if (PREFETCH_EN && buf_valid_q && (pc_d == fetch_addr_q)) begin
                        state_d = READY;
                    end else begin
                        fetch_addr_d = pc_d;
                        buf_valid_d  = 1'b0;
                        state_d      = REQ;
                    end
                end
            end
            REQ: begin
                if (mark_stale) begin
                    stale_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_valid) begin
                    if (stale_q || mark_stale) begin
                        stale_d      = 1'b0;
                        spec_d       = 1'b0;
                        fetch_addr_d = pc_d;
                        state_d      = REQ;
                    end else begin
                        buf_d  = bus.mem_rd_data;
                        spec_d = 1'b0;
                        if (spec_q && (pc_d != fetch_addr_q)) begin
                            buf_valid_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = READY;
                        end
                    end
                end else if (mark_stale) begin
                    stale_d = 1'b1;
                end
            end
            READY: begin
                // The IR load takes the buffered word even if the PC moves this same cycle.
                if (bus.instr_en) begin
                    ir_d = buf_q;
                    if (PREFETCH_EN) begin
                        fetch_addr_d = pc_q + ADDR_WIDTH'(1);
                        spec_d       = 1'b1;
                        buf_valid_d  = 1'b0;
                        state_d      = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pc_change) begin
                    fetch_addr_d = pc_d;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            ir_q         <= 16'h0000;
            buf_q        <= 16'h0000;
            stale_q      <= 1'b0;
            spec_q       <= 1'b0;
            buf_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            ir_q         <= ir_d;
            buf_q        <= buf_d;
            stale_q      <= stale_d;
            spec_q       <= spec_d;
            buf_valid_q  <= buf_valid_d;
        end
    end

    assign bus.mem_addr    = fetch_addr_q;
    assign bus.mem_rd_req  = (state_q == REQ);
    assign bus.instr_ready = (state_q == READY);
    assign bus.opcode      = ir_q[15:12];
    assign bus.rdest       = ir_q[11:8];
    assign bus.opcode_ext  = ir_q[7:4];
    assign bus.rsrc        = ir_q[3:0];
    assign bus.imm8        = ir_q[7:0];
    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_q + ADDR_WIDTH'(1);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - Directed and randomized checks of instr_fetch_unit against a PC/IR model
// Build with FETCH_PREFETCH_EN defined to exercise the prefetch sequence instead of the default-mode tests.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_WIDTH(16)) bus ();

    instr_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ir_now();
        return {bus.opcode, bus.rdest, bus.opcode_ext, bus.rsrc};
    endfunction

    task automatic pc_cmd(input logic [1:0] mode, input logic [15:0] tgt, input logic [15:0] exp_pc);
        bus.pc_en = 1'b1;
        bus.pc_addr_mode = mode;
        bus.jump_target = tgt;
        tick();
        bus.pc_en = 1'b0;
        check("pc_cmd", 32'(bus.pc), 32'(exp_pc));
    endtask

    // Full fetch with memory answering one cycle after the request, then an IR load.
    task automatic do_fetch(input logic [15:0] word, input logic [15:0] exp_addr);
        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        check("req", 32'(bus.mem_rd_req), 32'd1);
        check("req_addr", 32'(bus.mem_addr), 32'(exp_addr));
        tick();
        check("req_pulse", 32'(bus.mem_rd_req), 32'd0);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = word;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("ready", 32'(bus.instr_ready), 32'd1);
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("ir_load", 32'(ir_now()), 32'(word));
        check("imm8", 32'(bus.imm8), 32'(word[7:0]));
        check("ready_drop", 32'(bus.instr_ready), 32'd0);
    endtask

    logic [15:0] m_pc, m_ir, old_ir, r_addr;
    logic [1:0]  p_mode;
    logic [15:0] p_jt;
    bit          p_instr_en, p_pc_en, p_ready, pend;
    int          cnt, loads;

    initial begin
        reset = 1'b1;
        bus.next_instr = 1'b0;
        bus.instr_en = 1'b0;
        bus.pc_en = 1'b0;
        bus.pc_addr_mode = 2'b11;
        bus.jump_target = 16'h0000;
        bus.mem_rd_data = 16'h0000;
        bus.mem_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(bus.pc), 32'h0000);
        check("rst_pc_plus1", 32'(bus.pc_plus1), 32'h0001);
        check("rst_ready", 32'(bus.instr_ready), 32'd0);
        check("rst_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_ir", 32'(ir_now()), 32'h0000);
        reset = 1'b0;
        tick();

        do_fetch(16'h0521, 16'h0000);
        check("opcode", 32'(bus.opcode), 32'h0);
        check("rdest", 32'(bus.rdest), 32'h5);
        check("opcode_ext", 32'(bus.opcode_ext), 32'h2);
        check("rsrc", 32'(bus.rsrc), 32'h1);

`ifdef FETCH_PREFETCH_EN
        check("pf_req0", 32'(bus.mem_rd_req), 32'd1);
        check("pf_addr0", 32'(bus.mem_addr), 32'h0001);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h00FE;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("pf_park", 32'(bus.instr_ready), 32'd0);
        pc_cmd(2'b10, 16'h0004, 16'h0004);
        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        check("pf_req4", 32'(bus.mem_addr), 32'h0004);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h4004;
        tick();
        bus.mem_rd_valid = 1'b0;
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("pf_ir4", 32'(ir_now()), 32'h4004);
        check("pf_spec_req", 32'(bus.mem_rd_req), 32'd1);
        check("pf_spec_addr", 32'(bus.mem_addr), 32'h0005);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h5005;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("pf_wait_pc", 32'(bus.instr_ready), 32'd0);
        pc_cmd(2'b00, 16'h0000, 16'h0005);
        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        check("pf_hit_ready", 32'(bus.instr_ready), 32'd1);
        check("pf_hit_noreq", 32'(bus.mem_rd_req), 32'd0);
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("pf_ir5", 32'(ir_now()), 32'h5005);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h6006;
        tick();
        bus.mem_rd_valid = 1'b0;
        pc_cmd(2'b01, 16'h0000, 16'h000A);
        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        check("pf_miss_req", 32'(bus.mem_rd_req), 32'd1);
        check("pf_miss_addr", 32'(bus.mem_addr), 32'h000A);
        check("pf_miss_ready", 32'(bus.instr_ready), 32'd0);
`else
        do_fetch(16'h00FE, 16'h0000);
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("ir_hold_idle", 32'(ir_now()), 32'h00FE);
        pc_cmd(2'b10, 16'h0010, 16'h0010);
        pc_cmd(2'b00, 16'h0000, 16'h0011);
        pc_cmd(2'b01, 16'h0000, 16'h000F);
        pc_cmd(2'b10, 16'h1234, 16'h1234);
        pc_cmd(2'b11, 16'hBEEF, 16'h1234);
        pc_cmd(2'b10, 16'hFFFF, 16'hFFFF);
        check("pc_plus1_wrap", 32'(bus.pc_plus1), 32'h0000);
        pc_cmd(2'b00, 16'h0000, 16'h0000);

        // Jump while waiting: the in-flight word must be dropped and 0x0040 refetched.
        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        check("stale_req0", 32'(bus.mem_addr), 32'h0000);
        tick();
        pc_cmd(2'b10, 16'h0040, 16'h0040);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'hAAAA;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("refetch_req", 32'(bus.mem_rd_req), 32'd1);
        check("refetch_addr", 32'(bus.mem_addr), 32'h0040);
        check("refetch_ready", 32'(bus.instr_ready), 32'd0);
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h7C3D;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("refetch_rdy", 32'(bus.instr_ready), 32'd1);
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("refetch_ir", 32'(ir_now()), 32'h7C3D);

        bus.next_instr = 1'b1;
        tick();
        bus.next_instr = 1'b0;
        tick();
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = 16'h1111;
        #2 reset = 1'b1;
        #1;
        check("arst_pc", 32'(bus.pc), 32'h0000);
        check("arst_ready", 32'(bus.instr_ready), 32'd0);
        check("arst_req", 32'(bus.mem_rd_req), 32'd0);
        check("arst_ir", 32'(ir_now()), 32'h0000);
        tick();
        reset = 1'b0;
        tick();
        bus.mem_rd_valid = 1'b0;
        check("late_valid_ready", 32'(bus.instr_ready), 32'd0);
        bus.instr_en = 1'b1;
        tick();
        bus.instr_en = 1'b0;
        check("late_valid_ir", 32'(ir_now()), 32'h0000);

        // Random phase: the model tracks only PC arithmetic and which word the IR must hold.
        m_pc = 16'h0000;
        m_ir = 16'h0000;
        p_instr_en = 1'b0;
        p_pc_en = 1'b0;
        p_mode = 2'b11;
        p_jt = 16'h0000;
        p_ready = 1'b0;
        pend = 1'b0;
        cnt = 0;
        loads = 0;
        r_addr = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            old_ir = m_ir;
            if (p_instr_en && p_ready) begin
                m_ir = mem_word(m_pc);
                loads++;
            end
            if (p_pc_en) begin
                case (p_mode)
                    2'b00:   m_pc = m_pc + 16'd1;
                    2'b01:   m_pc = m_pc + {{8{old_ir[7]}}, old_ir[7:0]};
                    2'b10:   m_pc = p_jt;
                    default: m_pc = m_pc;
                endcase
            end
            check("rnd_pc", 32'(bus.pc), 32'(m_pc));
            check("rnd_pc_plus1", 32'(bus.pc_plus1), 32'(m_pc + 16'd1));
            check("rnd_ir", 32'(ir_now()), 32'(m_ir));

            bus.mem_rd_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data = mem_word(r_addr);
                    pend = 1'b0;
                end
            end
            if (bus.mem_rd_req) begin
                check("rnd_req_addr", 32'(bus.mem_addr), 32'(m_pc));
                r_addr = bus.mem_addr;
                cnt = int'($urandom_range(1, 3));
                pend = 1'b1;
            end

            bus.next_instr = ($urandom_range(0, 1) == 1);
            bus.instr_en = ($urandom_range(0, 2) != 0);
            bus.pc_en = ($urandom_range(0, 5) == 0);
            bus.pc_addr_mode = 2'($urandom_range(0, 3));
            bus.jump_target = 16'($urandom);
            p_instr_en = bus.instr_en;
            p_pc_en = bus.pc_en;
            p_mode = bus.pc_addr_mode;
            p_jt = bus.jump_target;
            p_ready = bus.instr_ready;
            tick();
        end
        check("rnd_progress", 32'(loads >= 100), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
